// File: rtl/gate_sweep_pkg.sv
// Shared types and the golden-output model for the two-input gate sweep sequencer.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 8;
  localparam int MASK_W      = NUM_VECTORS;

  // Expected {out_not, out_and, out_or} for input vector {a, b}.
  function automatic logic [2:0] golden_out(input logic [1:0] ab);
    return {~ab[1], ab[1] & ab[0], ab[1] | ab[0]};
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Host handshake plus gate-datapath connections of the sweep sequencer.
interface gate_sweep_ctrl_if;
  import gate_sweep_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic              gate_a;
  logic              gate_b;
  logic              out_not;
  logic              out_and;
  logic              out_or;
  logic [MASK_W-1:0] fail_mask;
  logic [ERR_W-1:0]  err_count;

  // master: host together with the gate datapath; slave: the sequencer.
  modport master (
    output start, out_not, out_and, out_or,
    input  busy, done, pass, gate_a, gate_b, fail_mask, err_count
  );

  modport slave (
    input  start, out_not, out_and, out_or,
    output busy, done, pass, gate_a, gate_b, fail_mask, err_count
  );

endinterface

// File: rtl/gate_sweep_golden.sv
// Combinational golden check of the datapath outputs for the applied vector.
module gate_sweep_golden
  import gate_sweep_pkg::*;
(
  input  logic [1:0] vec,
  input  logic       out_not,
  input  logic       out_and,
  input  logic       out_or,
  output logic       mismatch
);

  assign mismatch = ({out_not, out_and, out_or} != golden_out(vec));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four {a,b} vectors through a gate datapath and tallies mismatches.
// Optional: GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input logic              clk,
  input logic              rst_n,
  gate_sweep_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        vec_q, vec_d;
  logic [3:0]        pass_idx_q, pass_idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              mismatch;

  gate_sweep_golden u_golden (
    .vec      (vec_q),
    .out_not  (bus.out_not),
    .out_and  (bus.out_and),
    .out_or   (bus.out_or),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vec_q      <= '0;
      pass_idx_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mask_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      pass_idx_q <= pass_idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vec_d      = vec_q;
    pass_idx_d = pass_idx_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    mask_d     = mask_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d     = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          pass_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        vec_d   = idx_q;
        cnt_d   = SETTLE_LD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // The count saturates but the mask keeps recording failing vectors.
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          if (err_q != '1) err_d = err_q + 8'd1;
        end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = ST_DONE;
        end else
`endif
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_APPLY;
        end else if (pass_idx_q != LAST_PASS) begin
          idx_d      = '0;
          pass_idx_d = pass_idx_q + 4'd1;
          state_d    = ST_APPLY;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.gate_a    = vec_q[1];
  assign bus.gate_b    = vec_q[0];
  assign bus.fail_mask = mask_q;
  assign bus.err_count = err_q;

endmodule
